mac_array: RTL and testbench

MAC_ARRAY -- requirements
Module: mac_array

---
 rtl/mac_array_if.sv | 31 +++
 rtl/mac_array.sv | 166 ++++++++++++++++
 tb/tb_mac_array.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/mac_array_if.sv
// Handshake bundle for mac_array: beat input channel plus result output channel.
// master = beat producer / result consumer, slave = the MAC engine.
interface mac_array_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 4,
  parameter int MAX_BEATS  = 16,
  parameter int ACC_WIDTH  = DATA_WIDTH * 3
);
  localparam int CNT_WIDTH = $clog2(MAX_BEATS + 1);

  logic                        in_valid;
  logic                        in_ready;
  logic [LANES*DATA_WIDTH-1:0] in_a;
  logic [LANES*DATA_WIDTH-1:0] in_b;
  logic                        in_last;
  logic                        out_valid;
  logic                        out_ready;
  logic [ACC_WIDTH-1:0]        out_data;
  logic [CNT_WIDTH-1:0]        out_count;
  logic                        out_sat;

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_sat
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_sat
  );
endinterface

// File: rtl/mac_array.sv
// Pipelined multi-lane unsigned dot-product accumulator (products, lane sum, accumulate).
// Define MAC_ARRAY_SAT_EN to saturate the accumulator instead of wrapping it.
module mac_array #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 4,
  parameter int MAX_BEATS  = 16,
  parameter int ACC_WIDTH  = DATA_WIDTH * 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  mac_array_if.slave  bus
);
  localparam int PROD_WIDTH = 2 * DATA_WIDTH;
  localparam int SUM_WIDTH  = 2 * DATA_WIDTH + $clog2(LANES);
  localparam int CNT_WIDTH  = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                 r_state;
  logic [PROD_WIDTH-1:0]  r_s1_prod [LANES];
  logic                   r_s1_vld;
  logic                   r_s1_last;
  logic [SUM_WIDTH-1:0]   r_s2_sum;
  logic                   r_s2_vld;
  logic                   r_s2_last;
  logic                   r_s3_last;
  logic [ACC_WIDTH-1:0]   r_acc;
  logic [CNT_WIDTH-1:0]   r_count;
  logic                   r_out_valid;

  logic [PROD_WIDTH-1:0]  w_prod [LANES];
  logic [SUM_WIDTH-1:0]   w_lane_sum;
  logic [ACC_WIDTH-1:0]   w_acc_next;
  logic                   w_in_ready;
  logic                   w_accept;
  logic                   w_last_beat;
  logic                   w_out_fire;
  logic                   w_flush;

  assign w_flush     = rst || clr;
  assign w_in_ready  = (r_state == ACCUM) && !w_flush;
  assign w_accept    = bus.in_valid && w_in_ready;
  // The MAX_BEATS-th beat closes the packet even without in_last.
  assign w_last_beat = bus.in_last || (r_count == CNT_WIDTH'(MAX_BEATS - 1));
  assign w_out_fire  = r_out_valid && bus.out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign w_prod[gi] = PROD_WIDTH'(bus.in_a[gi*DATA_WIDTH +: DATA_WIDTH])
                        * PROD_WIDTH'(bus.in_b[gi*DATA_WIDTH +: DATA_WIDTH]);
    end
  endgenerate

  always_comb begin
    w_lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      w_lane_sum = w_lane_sum + SUM_WIDTH'(r_s1_prod[i]);
    end
  end

`ifdef MAC_ARRAY_SAT_EN
  logic [ACC_WIDTH:0] w_acc_sum;
  logic               w_ovf;
  logic               r_sat;

  assign w_acc_sum  = {1'b0, r_acc} + (ACC_WIDTH+1)'(r_s2_sum);
  assign w_ovf      = w_acc_sum[ACC_WIDTH];
  assign w_acc_next = w_ovf ? {ACC_WIDTH{1'b1}} : w_acc_sum[ACC_WIDTH-1:0];

  // Sticky until the result is consumed or the engine is flushed.
  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_sat <= 1'b0;
    end else if (r_state == HOLD && w_out_fire) begin
      r_sat <= 1'b0;
    end else if (r_s2_vld && w_ovf) begin
      r_sat <= 1'b1;
    end
  end

  assign bus.out_sat = r_sat;
`else
  assign w_acc_next  = r_acc + ACC_WIDTH'(r_s2_sum);
  assign bus.out_sat = 1'b0;
`endif

  // S1: per-lane products, captured only for accepted beats.
  always_ff @(posedge clk) begin
    if (w_flush) begin
      for (int i = 0; i < LANES; i++) begin
        r_s1_prod[i] <= '0;
      end
    end else if (w_accept) begin
      for (int i = 0; i < LANES; i++) begin
        r_s1_prod[i] <= w_prod[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_state     <= ACCUM;
      r_s1_vld    <= 1'b0;
      r_s1_last   <= 1'b0;
      r_s2_sum    <= '0;
      r_s2_vld    <= 1'b0;
      r_s2_last   <= 1'b0;
      r_s3_last   <= 1'b0;
      r_acc       <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_s1_vld  <= w_accept;
      r_s1_last <= w_accept && w_last_beat;
      r_s2_vld  <= r_s1_vld;
      r_s2_last <= r_s1_last;
      r_s3_last <= r_s2_vld && r_s2_last;
      if (r_s1_vld) begin
        r_s2_sum <= w_lane_sum;
      end
      if (r_s2_vld) begin
        r_acc <= w_acc_next;
      end
      if (w_accept) begin
        r_count <= r_count + CNT_WIDTH'(1);
      end

      case (r_state)
        ACCUM: begin
          if (w_accept && w_last_beat) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          // One cycle after the final lane sum lands in the accumulator.
          if (r_s3_last) begin
            r_state     <= HOLD;
            r_out_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (w_out_fire) begin
            r_state     <= ACCUM;
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_count     <= '0;
          end
        end
        default: begin
          r_state <= ACCUM;
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_acc;
  assign bus.out_count = r_count;
endmodule

// File: tb/tb_mac_array.sv
// Directed scoreboard bench for mac_array (4 lanes x 8 bit, MAX_BEATS=4, ACC_WIDTH=18).
module tb_mac_array;
  localparam int DW  = 8;
  localparam int LN  = 4;
  localparam int MB  = 4;
  localparam int AW  = 18;
  localparam int CW  = $clog2(MB + 1);

  typedef struct {
    logic [AW-1:0] data;
    logic [CW-1:0] count;
    logic          sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic clr;
  int   vectors     = 0;
  int   miscompares = 0;
  int   edge_cnt    = 0;
  int   last_acc_edge = 0;
  bit   prev_ov     = 1'b0;
  exp_t sb_q [$];

  mac_array_if #(.DATA_WIDTH(DW), .LANES(LN), .MAX_BEATS(MB), .ACC_WIDTH(AW)) bus ();

  mac_array #(.DATA_WIDTH(DW), .LANES(LN), .MAX_BEATS(MB), .ACC_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [AW-1:0] d, input logic [CW-1:0] c, input logic s);
    exp_t e;
    e.data = d; e.count = c; e.sat = s;
    sb_q.push_back(e);
  endtask

  // Entered and left at posedge+1; holds the beat until it is accepted.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic last);
    bit ok = 1'b0;
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_last = last;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        last_acc_edge = edge_cnt + 1;
        break;
      end
    end
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL beat_accept: got no accept expected accept within 64 cycles");
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    $display("beat a=%h b=%h last=%0b accepted at edge %0d", a, b, last, last_acc_edge);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !bus.out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL result_wait: got %0d pending expected 0 pending", sb_q.size());
    end
    @(posedge clk); #1;
  endtask

  // Monitor: latency on every rising out_valid, scoreboard pop on every handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (bus.out_valid && !prev_ov)
        chk("latency", edge_cnt - last_acc_edge, 32'd3);
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_result: got data=%0d expected no result", bus.out_data);
        end else begin
          e = sb_q.pop_front();
          $display("result data=%0d count=%0d sat=%0b (expected %0d/%0d/%0b)",
                   bus.out_data, bus.out_count, bus.out_sat, e.data, e.count, e.sat);
          chk("out_data", bus.out_data, e.data);
          chk("out_count", bus.out_count, e.count);
          chk("out_sat", bus.out_sat, e.sat);
        end
      end
      prev_ov = bus.out_valid;
    end
  end

  initial begin
    rst = 1'b1; clr = 1'b0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_count", bus.out_count, 0);
    chk("rst_out_sat", bus.out_sat, 0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;

    // Single beat: 1*5+2*6+3*7+4*8 = 70
    push_exp(18'd70, 3'd1, 1'b0);
    send(32'h04030201, 32'h08070605, 1'b1);
    wait_idle();

    // Two all-255 beats: 2*4*65025 = 520200 overflows 18 bits
`ifdef MAC_ARRAY_SAT_EN
    push_exp(18'd262143, 3'd2, 1'b1);
`else
    push_exp(18'd258056, 3'd2, 1'b0);
`endif
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    wait_idle();

    // HOLD backpressure with a beat waiting: 4*1*3 = 12, then 2*5 = 10
    bus.out_ready = 1'b0;
    push_exp(18'd12, 3'd1, 1'b0);
    send(32'h01010101, 32'h03030303, 1'b1);
    bus.in_valid = 1'b1; bus.in_a = 32'h00000002; bus.in_b = 32'h00000005; bus.in_last = 1'b1;
    begin
      bit seen = 1'b0;
      for (int n = 0; n < 16; n++) begin
        @(negedge clk);
        if (bus.out_valid) begin seen = 1'b1; break; end
      end
      chk("hold_reached", seen, 1);
    end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("hold_data", bus.out_data, 12);
      chk("hold_in_ready", bus.in_ready, 0);
      chk("hold_valid", bus.out_valid, 1);
    end
    @(posedge clk); #1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_hs_in_ready", bus.in_ready, 1);
    last_acc_edge = edge_cnt + 1;
    push_exp(18'd10, 3'd1, 1'b0);
    @(posedge clk); #1; bus.in_valid = 1'b0;
    $display("beat a=00000002 b=00000005 last=1 accepted at edge %0d", last_acc_edge);
    wait_idle();

    // clr with two beats in flight, then 4*1*1 = 4
    send(32'h02020202, 32'h02020202, 1'b0);
    send(32'h02020202, 32'h02020202, 1'b0);
    clr = 1'b1;
    @(negedge clk);
    chk("clr_in_ready", bus.in_ready, 0);
    @(posedge clk); #1; clr = 1'b0;
    @(negedge clk);
    chk("clr_out_data", bus.out_data, 0);
    chk("clr_out_count", bus.out_count, 0);
    chk("clr_out_valid", bus.out_valid, 0);
    @(posedge clk); #1;
    push_exp(18'd4, 3'd1, 1'b0);
    send(32'h01010101, 32'h01010101, 1'b1);
    wait_idle();

    // Forced last at MAX_BEATS: 4 beats of 8 = 32
    push_exp(18'd32, 3'd4, 1'b0);
    for (int n = 0; n < 4; n++) send(32'h01010101, 32'h02020202, 1'b0);
    @(negedge clk);
    chk("forced_last_in_ready", bus.in_ready, 0);
    wait_idle();

    // rst during DRAIN discards the packet
    send(32'h09090909, 32'h09090909, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("drain_rst_in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("drain_post_rst_in_ready", bus.in_ready, 1);
    for (int n = 0; n < 6; n++) begin
      chk("drain_rst_no_valid", bus.out_valid, 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    push_exp(18'd10, 3'd1, 1'b0);
    send(32'h04030201, 32'h01010101, 1'b1);
    wait_idle();

    chk("sb_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
